turn_controller: RTL and testbench

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/turn_controller_pkg.sv | 29 ++
 rtl/turn_controller_win_detect.sv | 26 ++
 rtl/turn_controller.sv | 148 ++++++++++++++
 tb/tb_turn_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_controller_pkg.sv
// Shared types and codes for the tic-tac-toe turn controller.
package turn_controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P1    = 3'd1,
    P2    = 3'd2,
    CHECK = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] PL1   = 2'b01;
  localparam logic [1:0] PL2   = 2'b10;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] P1_WIN = 2'b01;
  localparam logic [1:0] P2_WIN = 2'b10;
  localparam logic [1:0] DRAW   = 2'b11;

  // Winner code for one line of three squares, NONE unless all three match a player.
  function automatic logic [1:0] line_owner(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
    if (a != EMPTY && a == b && b == c)
      return (a == PL1) ? P1_WIN : P2_WIN;
    return NONE;
  endfunction

endpackage

// File: rtl/turn_controller_win_detect.sv
// Combinational line check: reports which player (if any) owns a full row, column or diagonal.
module win_detect
  import turn_controller_pkg::*;
(
  input  logic [17:0] board,
  output logic [1:0]  win
);

  logic [1:0] sq    [9];
  logic [1:0] lines [8];

  always_comb begin
    for (int k = 0; k < 9; k++) sq[k] = board[2*k +: 2];
    lines[0] = line_owner(sq[0], sq[1], sq[2]);
    lines[1] = line_owner(sq[3], sq[4], sq[5]);
    lines[2] = line_owner(sq[6], sq[7], sq[8]);
    lines[3] = line_owner(sq[0], sq[3], sq[6]);
    lines[4] = line_owner(sq[1], sq[4], sq[7]);
    lines[5] = line_owner(sq[2], sq[5], sq[8]);
    lines[6] = line_owner(sq[0], sq[4], sq[8]);
    lines[7] = line_owner(sq[2], sq[4], sq[6]);
    win = NONE;
    for (int l = 0; l < 8; l++) if (win == NONE) win = lines[l];
  end

endmodule

// File: rtl/turn_controller.sv
// Tic-tac-toe turn controller: validates moves, writes the board, detects win/draw.
// Defining MOVE_TIMEOUT_EN adds a per-turn forfeit timer and the timeout_flag port.
//
// state | meaning
// IDLE  | after reset, waiting for start
// P1    | player 1 to move
// P2    | player 2 to move
// CHECK | evaluate lines on the just-written board
// OVER  | game finished, winner valid
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        PL1_req,
  input  logic        PL2_req,
  input  logic [3:0]  PL1_sel,
  input  logic [3:0]  PL2_sel,
  output logic [8:0]  PL1_en,
  output logic [8:0]  PL2_en,
  output logic [17:0] board,
  output logic        turn,
  output logic        illegal_move,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [3:0]  move_count
`ifdef MOVE_TIMEOUT_EN
  ,
  output logic        timeout_flag
`endif
);

  state_t     state;
  logic       own_req, in_range, legal, tmo_hit;
  logic [3:0] own_sel, sq_idx;
  logic [1:0] own_code, target, line_win;
  logic [8:0] onehot;

  win_detect u_win_detect (
    .board (board),
    .win   (line_win)
  );

  // Only the player whose state is active can have a request considered.
  always_comb begin
    own_req = 1'b0;
    if (state == P1) own_req = PL1_req;
    else if (state == P2) own_req = PL2_req;
    own_sel  = turn ? PL2_sel : PL1_sel;
    own_code = turn ? PL2 : PL1;
    sq_idx   = own_sel - 4'd1;
    in_range = (own_sel >= 4'd1) && (own_sel <= 4'd9);
    target   = 2'(board >> {sq_idx, 1'b0});
    legal    = own_req && in_range && (target == EMPTY);
    onehot   = 9'd1 << sq_idx;
  end

  assign game_over = (state == OVER);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      board        <= '0;
      move_count   <= '0;
      winner       <= NONE;
      turn         <= 1'b0;
      PL1_en       <= '0;
      PL2_en       <= '0;
      illegal_move <= 1'b0;
    end else begin
      PL1_en       <= '0;
      PL2_en       <= '0;
      illegal_move <= 1'b0;
      if (start) begin
        state      <= P1;
        board      <= '0;
        move_count <= '0;
        winner     <= NONE;
        turn       <= 1'b0;
      end else begin
        case (state)
          P1, P2: begin
            // A legal move arriving on the last timer cycle still counts.
            if (legal) begin
              board <= board | (18'(own_code) << {sq_idx, 1'b0});
              if (turn) PL2_en <= onehot;
              else      PL1_en <= onehot;
              if (move_count != 4'd9) move_count <= move_count + 4'd1;
              state <= CHECK;
            end else if (tmo_hit) begin
              state <= turn ? P1 : P2;
              turn  <= ~turn;
            end else if (own_req) begin
              illegal_move <= 1'b1;
            end
          end
          CHECK: begin
            if (line_win != NONE) begin
              winner <= line_win;
              state  <= OVER;
            end else if (move_count == 4'd9) begin
              winner <= DRAW;
              state  <= OVER;
            end else begin
              state <= turn ? P1 : P2;
              turn  <= ~turn;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= 1'b0;
      if (start || legal || !(state == P1 || state == P2)) begin
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        tmo_cnt      <= '0;
        timeout_flag <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic timeout_unused;

  assign tmo_hit        = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed scenarios plus random games against a
// game-level model (wins found with magic-square sums). Timeout test runs with MOVE_TIMEOUT_EN.
module tb_turn_controller;

  localparam int TO_CYCLES =
`ifdef MOVE_TIMEOUT_EN
    8;
`else
    1000;
`endif

  logic        clock = 1'b0;
  logic        reset, start, PL1_req, PL2_req;
  logic [3:0]  PL1_sel, PL2_sel;
  logic [8:0]  PL1_en, PL2_en;
  logic [17:0] board;
  logic        turn, illegal_move, game_over;
  logic [1:0]  winner;
  logic [3:0]  move_count;
`ifdef MOVE_TIMEOUT_EN
  logic        timeout_flag;
`endif

  always #5 clock = ~clock;

  turn_controller #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .PL1_req      (PL1_req),
    .PL2_req      (PL2_req),
    .PL1_sel      (PL1_sel),
    .PL2_sel      (PL2_sel),
    .PL1_en       (PL1_en),
    .PL2_en       (PL2_en),
    .board        (board),
    .turn         (turn),
    .illegal_move (illegal_move),
    .winner       (winner),
    .game_over    (game_over),
    .move_count   (move_count)
`ifdef MOVE_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: cell owners 0/1/2, whose turn it is, moves made, result.
  int cells [1:9];
  int magic [1:9];
  int owner, cnt, mwin;
  bit active, over;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [17:0] exp_board();
    logic [17:0] b = '0;
    for (int k = 1; k <= 9; k++) b |= 18'(cells[k]) << (2 * (k - 1));
    return b;
  endfunction

  function automatic bit has_line(input int p);
    for (int i = 1; i <= 7; i++)
      for (int j = i + 1; j <= 8; j++)
        for (int k = j + 1; k <= 9; k++)
          if (cells[i] == p && cells[j] == p && cells[k] == p &&
              magic[i] + magic[j] + magic[k] == 15) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] pick_sel();
    int v;
    if ($urandom_range(0, 9) < 8) return 4'($urandom_range(1, 9));
    v = $urandom_range(9, 15);
    return (v == 9) ? 4'd0 : 4'(v);
  endfunction

  task automatic model_clear(input bit act);
    for (int k = 1; k <= 9; k++) cells[k] = 0;
    owner  = 1;
    cnt    = 0;
    mwin   = 0;
    active = act;
    over   = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear(1'b1);
    chk("start_board", board, exp_board());
    chk("start_turn", turn, 0);
    chk("start_count", move_count, 0);
    chk("start_winner", winner, 0);
    chk("start_over", game_over, 0);
  endtask

  task automatic try_move(input bit r1, input logic [3:0] s1, input bit r2, input logic [3:0] s2);
    logic [17:0] b0;
    logic [8:0]  oh;
    int p, s;
    bit evald, legal;
    b0    = exp_board();
    p     = owner;
    evald = active && !over && ((owner == 1 && r1) || (owner == 2 && r2));
    s     = (owner == 1) ? int'(s1) : int'(s2);
    legal = 1'b0;
    if (evald && s >= 1 && s <= 9) legal = (cells[s] == 0);
    PL1_req = r1; PL1_sel = s1; PL2_req = r2; PL2_sel = s2;
    step();
    PL1_req = 1'b0; PL2_req = 1'b0;
    if (legal) begin
      cells[s] = p;
      cnt++;
      oh = 9'd1 << (s - 1);
      chk("move_en1", PL1_en, (p == 1) ? oh : 9'd0);
      chk("move_en2", PL2_en, (p == 2) ? oh : 9'd0);
      chk("move_board", board, exp_board());
      chk("move_count", move_count, cnt);
      chk("move_turn", turn, p - 1);
      chk("move_illegal", illegal_move, 0);
      step();
      if (has_line(p)) begin
        mwin = p; over = 1'b1;
      end else if (cnt == 9) begin
        mwin = 3; over = 1'b1;
      end else begin
        owner = 3 - p;
      end
      chk("check_winner", winner, mwin);
      chk("check_over", game_over, over);
      chk("check_turn", turn, owner - 1);
      chk("check_en", {PL1_en, PL2_en}, 0);
    end else begin
      chk("req_illegal", illegal_move, evald);
      chk("req_board", board, b0);
      chk("req_en", {PL1_en, PL2_en}, 0);
      chk("req_turn", turn, owner - 1);
      step();
      chk("req_pulse_end", illegal_move, 0);
    end
  endtask

  initial begin
    magic = '{2, 7, 6, 9, 5, 1, 4, 3, 8};
    reset = 1'b1; start = 1'b0;
    PL1_req = 1'b0; PL2_req = 1'b0; PL1_sel = 4'd0; PL2_sel = 4'd0;
    model_clear(1'b0);
    #1;
    chk("reset_board", board, 0);
    chk("reset_outputs", {turn, illegal_move, winner, game_over, move_count}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    try_move(1'b1, 4'd1, 1'b0, 4'd0);           // IDLE ignores requests
    start_game();
    try_move(1'b1, 4'd1, 1'b0, 4'd0);
    chk("first_move_turn", turn, 1);
    try_move(1'b0, 4'd0, 1'b1, 4'd1);           // occupied square
    try_move(1'b0, 4'd0, 1'b1, 4'd10);          // out of range
    try_move(1'b0, 4'd0, 1'b1, 4'd0);
    try_move(1'b1, 4'd4, 1'b1, 4'd5);           // both request, only P2 owns the turn

    // Start wins over a simultaneous move request
    PL1_req = 1'b1; PL1_sel = 4'd7; start = 1'b1;
    step();
    PL1_req = 1'b0; start = 1'b0;
    model_clear(1'b1);
    chk("restart_board", board, 0);
    chk("restart_en", PL1_en, 0);
    chk("restart_count", move_count, 0);
    chk("restart_turn", turn, 0);

    // Player 1 wins the top row
    try_move(1'b1, 4'd1, 1'b0, 4'd0);
    try_move(1'b0, 4'd0, 1'b1, 4'd4);
    try_move(1'b1, 4'd2, 1'b0, 4'd0);
    try_move(1'b0, 4'd0, 1'b1, 4'd5);
    try_move(1'b1, 4'd3, 1'b0, 4'd0);
    chk("row_win", winner, 2'b01);
    chk("row_over", game_over, 1);
    try_move(1'b1, 4'd7, 1'b1, 4'd8);

    // Full board, no line
    start_game();
    begin
      int seq [9];
      seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
      for (int i = 0; i < 9; i++)
        if (i % 2 == 0) try_move(1'b1, 4'(seq[i]), 1'b0, 4'd0);
        else            try_move(1'b0, 4'd0, 1'b1, 4'(seq[i]));
    end
    chk("draw_winner", winner, 2'b11);
    chk("draw_count", move_count, 9);
    start_game();

    // Reset while in CHECK discards the move
    PL1_req = 1'b1; PL1_sel = 4'd9;
    step();
    PL1_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_board", board, 0);
    chk("mid_reset_en", {PL1_en, PL2_en}, 0);
    chk("mid_reset_outputs", {turn, illegal_move, winner, game_over, move_count}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    model_clear(1'b0);
    try_move(1'b1, 4'd2, 1'b0, 4'd0);

`ifndef MOVE_TIMEOUT_EN
    for (int g = 0; g < 25; g++) begin
      start_game();
      for (int a = 0; a < 40 && !over; a++) begin
        bit r1, r2;
        r1 = ($urandom_range(0, 3) != 0);
        r2 = ($urandom_range(0, 3) != 0);
        try_move(r1, pick_sel(), r2, pick_sel());
      end
      if (over) begin
        for (int a = 0; a < 3; a++) try_move(1'b1, pick_sel(), 1'b1, pick_sel());
      end
    end
`else
    begin : timeout_test
      int n;
      start_game();
      for (n = 1; n <= 20; n++) begin
        step();
        if (timeout_flag) break;
      end
      chk("timeout_cycle", n, TO_CYCLES);
      chk("timeout_turn", turn, 1);
      chk("timeout_board", board, 0);
      step();
      chk("timeout_pulse_end", timeout_flag, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
